// File: rtl/hsv_core_commit_select.sv
// rtl/hsv_core_commit_select.sv - N-channel in-order commit selector with flush handshake
//
// Purpose: accepts the single unit result whose token equals the next expected
// token, registers it toward commit, counts retired results and flags
// duplicate-token collisions.
//
// Ports:
//   clk_core, rst_core_n       core clock, asynchronous active-low reset
//   flush_req / flush_ack      flush request in, registered acknowledge out
//   unit_valid_i/unit_ready_o  per-unit result handshake
//   unit_token_i, unit_data_i  per-unit token and payload, unit i at slice i
//   out_valid_o / out_ready_i  registered commit handshake
//   out_data_o, out_unit_o     held payload and one-hot source unit
//   token_o                    next expected token
//   retired_o                  count of completed output handshakes
//   err_dup_o                  sticky duplicate-token flag
module hsv_core_commit_select #(
   parameter int NUM_UNITS = 5,
   parameter int DATA_W    = 64,
   parameter int TOKEN_W   = 3,
   parameter int CNT_W     = 64
) (
   input  logic                          clk_core,
   input  logic                          rst_core_n,
   input  logic                          flush_req,
   output logic                          flush_ack,
   input  logic [NUM_UNITS-1:0]          unit_valid_i,
   output logic [NUM_UNITS-1:0]          unit_ready_o,
   input  logic [NUM_UNITS*TOKEN_W-1:0]  unit_token_i,
   input  logic [NUM_UNITS*DATA_W-1:0]   unit_data_i,
   output logic                          out_valid_o,
   input  logic                          out_ready_i,
   output logic [DATA_W-1:0]             out_data_o,
   output logic [NUM_UNITS-1:0]          out_unit_o,
   output logic [TOKEN_W-1:0]            token_o,
   output logic [CNT_W-1:0]              retired_o,
   output logic                          err_dup_o
);

   typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

   state_t                r_state;
   state_t                w_state_nxt;

   logic                  r_out_valid;
   logic [DATA_W-1:0]     r_out_data;
   logic [NUM_UNITS-1:0]  r_out_unit;
   logic [TOKEN_W-1:0]    r_token;
   logic [CNT_W-1:0]      r_retired;
   logic                  r_err_dup;

   logic [NUM_UNITS-1:0]  w_match;
   logic [NUM_UNITS-1:0]  w_sel;
   logic [DATA_W-1:0]     w_sel_data;
   logic                  w_can_load;
   logic                  w_accept;
   logic                  w_out_hs;
   logic                  w_multi;

   always_comb begin
      w_match = '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         w_match[i] = unit_valid_i[i] && (unit_token_i[i*TOKEN_W +: TOKEN_W] == r_token);
      end
   end

   // Two's-complement trick isolates the lowest set bit of the match vector.
   assign w_sel   = w_match & (~w_match + NUM_UNITS'(1));
   // Clearing the lowest set bit leaves something only if two or more matched.
   assign w_multi = |(w_match & (w_match - NUM_UNITS'(1)));

   always_comb begin
      w_sel_data = '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         w_sel_data = w_sel_data | ({DATA_W{w_sel[i]}} & unit_data_i[i*DATA_W +: DATA_W]);
      end
   end

   assign w_can_load   = !flush_req && (!r_out_valid || out_ready_i);
   assign unit_ready_o = {NUM_UNITS{w_can_load}} & w_sel;
   assign w_accept     = |unit_ready_o;
   assign w_out_hs     = r_out_valid && out_ready_i;

   // FSM: state register
   always_ff @(posedge clk_core or negedge rst_core_n) begin
      if (!rst_core_n) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM: next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN:   if (flush_req)  w_state_nxt = ST_FLUSH;
         ST_FLUSH: if (!flush_req) w_state_nxt = ST_RUN;
         default:  w_state_nxt = ST_RUN;
      endcase
   end

   // FSM: outputs (decoded straight from the state flop, so flush_ack is registered)
   always_comb begin
      flush_ack = (r_state == ST_FLUSH);
   end

   // A handshake in the flush-request cycle still counts: the downstream side
   // already consumed the value, only the register contents are discarded.
   always_ff @(posedge clk_core or negedge rst_core_n) begin
      if (!rst_core_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_unit  <= '0;
         r_token     <= '0;
         r_retired   <= '0;
         r_err_dup   <= 1'b0;
      end else begin
         if (w_out_hs) begin
            r_retired <= r_retired + CNT_W'(1);
         end
         if (w_multi && w_can_load) begin
            r_err_dup <= 1'b1;
         end
         if (flush_req) begin
            r_out_valid <= 1'b0;
            r_token     <= '0;
         end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_unit  <= w_sel;
            r_token     <= r_token + TOKEN_W'(1);
         end else if (w_out_hs) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid_o = r_out_valid;
   assign out_data_o  = r_out_data;
   assign out_unit_o  = r_out_unit;
   assign token_o     = r_token;
   assign retired_o   = r_retired;
   assign err_dup_o   = r_err_dup;

endmodule
